// File: rtl/led_scan_ctrl.sv
// LED scan controller: time-multiplexes NUM_SRC 8-bit sources onto one
// inverting LED sink driver. Each slot is a BLANK interval followed by a SHOW
// interval, so two digits are never lit back to back. All outputs are registered
// and reflect the state register one cycle later. Dropping en, or asserting rst,
// blanks the outputs on the very next cycle.
module led_scan_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int DWELL   = 1024,
  parameter int BLANK   = 16,
  parameter int SEL_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 hold,
  input  logic [SEL_W-1:0]     hold_sel,
  input  logic [NUM_SRC*8-1:0] src_data,
  output logic [7:0]           led_data,
  output logic [NUM_SRC-1:0]   digit_n,
  output logic [SEL_W-1:0]     slot,
  output logic                 frame_tick
);

  localparam int MAX_C = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W = $clog2(MAX_C);
  localparam logic [CNT_W-1:0]   DWELL_LD  = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]   BLANK_LD  = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [SEL_W-1:0]   SLOT_ZERO = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0]   LAST_SLOT = SEL_W'(NUM_SRC - 1);
  localparam logic [NUM_SRC-1:0] DIGIT_OFF = {NUM_SRC{1'b1}};
  localparam logic [NUM_SRC-1:0] DIGIT_ONE = {{(NUM_SRC-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [SEL_W-1:0] slot_r, slot_s;     // slot being shown
  logic [SEL_W-1:0] nslot_r, nslot_s;   // slot to show after the current blank
  logic [7:0]       snap_r, snap_s;     // source snapshot taken at slot start
  logic [SEL_W-1:0] hold_slot_s;
  logic [SEL_W-1:0] rot_slot_s;
  logic             tick_s;

  // Sanitise hold_sel and compute the rotating successor of the current slot.
  always_comb begin
    if (32'(hold_sel) >= 32'(NUM_SRC)) begin
      hold_slot_s = SLOT_ZERO;
    end else begin
      hold_slot_s = hold_sel;
    end
    if (slot_r == LAST_SLOT) begin
      rot_slot_s = SLOT_ZERO;
    end else begin
      rot_slot_s = slot_r + {{(SEL_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic: IDLE -> BLANK -> SHOW -> BLANK ..., en=0 forces IDLE.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    slot_s  = slot_r;
    nslot_s = nslot_r;
    snap_s  = snap_r;
    tick_s  = 1'b0;
    if (!en) begin
      state_s = ST_IDLE;
      cnt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_BLANK;
          cnt_s   = BLANK_LD;
          nslot_s = hold ? hold_slot_s : SLOT_ZERO;
        end
        ST_BLANK: begin
          if (cnt_r == CNT_ZERO) begin
            state_s = ST_SHOW;
            cnt_s   = DWELL_LD;
            slot_s  = nslot_r;
            snap_s  = src_data[{nslot_r, 3'b000} +: 8];
          end else begin
            cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_SHOW: begin
          if (cnt_r == CNT_ZERO) begin
            state_s = ST_BLANK;
            cnt_s   = BLANK_LD;
            nslot_s = hold ? hold_slot_s : rot_slot_s;
            tick_s  = (slot_r == LAST_SLOT) && !hold;
          end else begin
            cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counter, slot bookkeeping and snapshot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      slot_r  <= SLOT_ZERO;
      nslot_r <= SLOT_ZERO;
      snap_r  <= 8'h00;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      slot_r  <= slot_s;
      nslot_r <= nslot_s;
      snap_r  <= snap_s;
    end
  end

  // Registered outputs: lit only in SHOW with en high, blanked otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_data   <= 8'h00;
      digit_n    <= DIGIT_OFF;
      slot       <= SLOT_ZERO;
      frame_tick <= 1'b0;
    end else if (en && (state_r == ST_SHOW)) begin
      led_data   <= snap_r;
      digit_n    <= ~(DIGIT_ONE << slot_r);
      slot       <= slot_r;
      frame_tick <= tick_s;
    end else begin
      led_data   <= 8'h00;
      digit_n    <= DIGIT_OFF;
      slot       <= slot_r;
      frame_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl with NUM_SRC=4, DWELL=8, BLANK=2. Directed phases
// queue the expected per-cycle outputs; a negedge monitor pops and compares
// them and also checks the one-digit and blank-gap invariants every cycle.
module tb_led_scan_ctrl;

  localparam int NUM_SRC = 4;
  localparam int DWELL   = 8;
  localparam int BLANK   = 2;
  localparam int SEL_W   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 hold;
  logic [SEL_W-1:0]     hold_sel;
  logic [NUM_SRC*8-1:0] src_data;
  logic [7:0]           led_data;
  logic [NUM_SRC-1:0]   digit_n;
  logic [SEL_W-1:0]     slot;
  logic                 frame_tick;

  typedef struct {
    logic [3:0] dig;
    logic [7:0] led;
    int         sl;     // -1: slot not checked this cycle
    logic       tick;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   blank_run = BLANK;
  logic [3:0] prev_dig = 4'hF;

  led_scan_ctrl #(
    .NUM_SRC (NUM_SRC),
    .DWELL   (DWELL),
    .BLANK   (BLANK),
    .SEL_W   (SEL_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .hold       (hold),
    .hold_sel   (hold_sel),
    .src_data   (src_data),
    .led_data   (led_data),
    .digit_n    (digit_n),
    .slot       (slot),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: the expectation describes outputs right after this edge.
  task automatic cyc(input logic [3:0] d, input logic [7:0] l, input int s, input logic t);
    exp_t e;
    @(posedge clk);
    e.dig = d; e.led = l; e.sl = s; e.tick = t;
    sb.push_back(e);
    #1;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) cyc(4'hF, 8'h00, -1, 1'b0);
  endtask

  task automatic show(input int s, input logic [7:0] v, input int n, input bit tick_last);
    logic [3:0] one;
    one = 4'b0001;
    for (int i = 0; i < n; i++)
      cyc(~(one << s), v, s, tick_last && (i == n - 1));
  endtask

  // Scoreboard pop plus invariants, sampled away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("digit_n", 32'(digit_n), 32'(e.dig));
      check_eq("led_data", 32'(led_data), 32'(e.led));
      check_eq("frame_tick", 32'(frame_tick), 32'(e.tick));
      if (e.sl >= 0) check_eq("slot", 32'(slot), e.sl);
    end
    check_eq("onehot", 32'($countones(~digit_n) <= 1), 32'd1);
    if (digit_n == 4'hF) begin
      blank_run++;
    end else begin
      if (prev_dig == 4'hF) check_eq("gap", 32'(blank_run >= BLANK), 32'd1);
      else check_eq("adjacent", 32'(digit_n), 32'(prev_dig));
      blank_run = 0;
    end
    prev_dig = digit_n;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; hold = 1'b0; hold_sel = 2'd0;
    src_data = 32'h44332211;

    // Reset held 3 cycles with en high.
    for (int i = 0; i < 3; i++) cyc(4'hF, 8'h00, 0, 1'b0);
    rst = 1'b0;

    // Rotation through one full frame and back to slot 0.
    blank(3);
    show(0, 8'h11, 8, 1'b0); blank(2);
    show(1, 8'h22, 8, 1'b0); blank(2);
    show(2, 8'h33, 8, 1'b0); blank(2);
    show(3, 8'h44, 8, 1'b1); blank(2);
    show(0, 8'h11, 8, 1'b0); blank(2);

    // Snapshot: source 1 changes mid-slot, visible only next frame.
    show(1, 8'h22, 4, 1'b0);
    src_data[15:8] = 8'h5A;
    show(1, 8'h22, 4, 1'b0); blank(2);
    show(2, 8'h33, 8, 1'b0); blank(2);
    show(3, 8'h44, 8, 1'b1); blank(2);
    show(0, 8'h11, 8, 1'b0); blank(2);
    show(1, 8'h5A, 8, 1'b0); blank(2);
    show(2, 8'h33, 8, 1'b0); blank(2);
    show(3, 8'h44, 8, 1'b1); blank(2);

    // Hold on slot 2 requested mid slot 0; slot 0 still completes.
    show(0, 8'h11, 3, 1'b0);
    hold = 1'b1; hold_sel = 2'd2;
    show(0, 8'h11, 5, 1'b0); blank(2);
    show(2, 8'h33, 8, 1'b0); blank(2);
    show(2, 8'h33, 8, 1'b0); blank(2);
    show(2, 8'h33, 4, 1'b0);
    hold = 1'b0;
    show(2, 8'h33, 4, 1'b0); blank(2);

    // Hold on the last slot suppresses frame_tick.
    hold = 1'b1; hold_sel = 2'd3;
    show(3, 8'h44, 8, 1'b0); blank(2);
    show(3, 8'h44, 4, 1'b0);
    hold = 1'b0;
    show(3, 8'h44, 4, 1'b1); blank(2);

    // Disable mid slot 2, then re-enable from slot 0.
    show(0, 8'h11, 8, 1'b0); blank(2);
    show(1, 8'h5A, 8, 1'b0); blank(2);
    show(2, 8'h33, 3, 1'b0);
    en = 1'b0;
    blank(3);
    en = 1'b1;
    blank(3);
    show(0, 8'h11, 8, 1'b0); blank(2);
    show(1, 8'h5A, 2, 1'b0);

    // Random stress; only the invariants are checked here.
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      rst      = ($urandom_range(0, 99) < 2);
      en       = ($urandom_range(0, 99) < 92);
      hold     = ($urandom_range(0, 99) < 20);
      hold_sel = SEL_W'($urandom_range(0, NUM_SRC - 1));
      src_data = $urandom;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
